// File: rtl/program_loader.sv
// Serial in-system programming engine: decodes LSB-first host commands and data
// frames, then issues single-cycle write strobes into the instruction memory.
module program_loader #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 14,
    parameter int WR_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_en,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int WC_W  = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;

    localparam logic [5:0] CMD_LOAD_DATA  = 6'h02;
    localparam logic [5:0] CMD_INC_ADDR   = 6'h06;
    localparam logic [5:0] CMD_BEGIN_PROG = 6'h08;
    localparam logic [5:0] CMD_RESET_ADDR = 6'h16;

    typedef enum logic [1:0] {IDLE, CMD, DATA, WRITE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WC_W-1:0]   wr_cnt;
    logic [DATA_W:0]   sh;
    logic [5:0]        cmd;
    logic              frame_ok;
    logic              bit_take, word_done, err_set, ld_wdata, inc_addr, clr_addr;

    // The shift register holds the earlier bits; the final bit is taken straight from bit_in.
    assign cmd      = {bit_in, sh[DATA_W -: 5]};
    assign frame_ok = ~sh[0] & ~bit_in;

    always_comb begin
        state_next = state;
        bit_take   = 1'b0;
        word_done  = 1'b0;
        err_set    = 1'b0;
        ld_wdata   = 1'b0;
        inc_addr   = 1'b0;
        clr_addr   = 1'b0;
        case (state)
            IDLE: if (prog_en) state_next = CMD;
            CMD: begin
                if (!prog_en) begin
                    state_next = IDLE;
                end else if (bit_valid) begin
                    bit_take = 1'b1;
                    if (bit_cnt == CNT_W'(5)) begin
                        word_done = 1'b1;
                        case (cmd)
                            CMD_LOAD_DATA:  state_next = DATA;
                            CMD_INC_ADDR:   inc_addr = 1'b1;
                            CMD_BEGIN_PROG: state_next = WRITE;
                            CMD_RESET_ADDR: clr_addr = 1'b1;
                            default:        err_set = 1'b1;
                        endcase
                    end
                end
            end
            DATA: begin
                if (!prog_en) begin
                    state_next = IDLE;
                end else if (bit_valid) begin
                    bit_take = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W + 1)) begin
                        word_done  = 1'b1;
                        ld_wdata   = frame_ok;
                        err_set    = ~frame_ok;
                        state_next = CMD;
                    end
                end
            end
            WRITE: begin
                err_set = bit_valid;
                if (wr_cnt == WC_W'(WR_WAIT - 1)) state_next = prog_en ? CMD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            wr_cnt    <= '0;
            sh        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (word_done || state_next != state) begin
                bit_cnt <= '0;
            end else if (bit_take) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (bit_take) sh <= {bit_in, sh[DATA_W:1]};
            wr_cnt <= (state == WRITE) ? wr_cnt + 1'b1 : '0;
            if (clr_addr) begin
                mem_addr <= '0;
            end else if (inc_addr) begin
                mem_addr <= mem_addr + 1'b1;
            end
            if (ld_wdata) mem_wdata <= sh[DATA_W:1];
            cpu_hold <= prog_en | busy;
            if (!prog_en) begin
                frame_err <= 1'b0;
            end else if (err_set) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign busy   = (state == WRITE);
    assign mem_we = (state == WRITE) && (wr_cnt == '0);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a 13-bit and a 3-bit-address instance share stimulus.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_en;
    logic        bit_valid;
    logic        bit_in;
    logic [12:0] mem_addr;
    logic [13:0] mem_wdata;
    logic        mem_we, cpu_hold, busy, frame_err;
    logic [2:0]  s_addr;
    logic [13:0] s_wdata;
    logic        s_we, s_hold, s_busy, s_ferr;

    int checks = 0;
    int errors = 0;

    program_loader #(.ADDR_W(13), .DATA_W(14), .WR_WAIT(4)) dut (
        .clk(clk), .reset(reset), .prog_en(prog_en), .bit_valid(bit_valid), .bit_in(bit_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_hold(cpu_hold),
        .busy(busy), .frame_err(frame_err)
    );

    program_loader #(.ADDR_W(3), .DATA_W(14), .WR_WAIT(4)) dut_small (
        .clk(clk), .reset(reset), .prog_en(prog_en), .bit_valid(bit_valid), .bit_in(bit_in),
        .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_we(s_we), .cpu_hold(s_hold),
        .busy(s_busy), .frame_err(s_ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = v[i];
        end
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    int  nb, nw;
    logic hold_ok;

    initial begin
        reset = 1'b1; prog_en = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        // Reset with bits toggling
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bit_valid = 1'b1; bit_in = i[0];
        end
        @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0;
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_hold",  32'(cpu_hold),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        reset = 1'b0;

        // Basic write
        prog_en = 1'b1;
        @(negedge clk);
        chk("hold_on", 32'(cpu_hold), 32'd1);
        send_bits(16'h0016, 6);
        send_bits(16'h0002, 6);
        send_bits(16'h7FFE, 16);
        chk("basic_wdata", 32'(mem_wdata), 32'h3FFF);
        send_bits(16'h0008, 6);
        chk("basic_we",    32'(mem_we),    32'd1);
        chk("basic_addr",  32'(mem_addr),  32'd0);
        nb = 0; nw = 0; hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nb += int'(busy);
            nw += int'(mem_we);
            if (cpu_hold !== 1'b1) hold_ok = 1'b0;
            @(negedge clk);
        end
        chk("basic_busy_cycles", 32'(nb), 32'd4);
        chk("basic_we_cycles",   32'(nw), 32'd1);
        chk("basic_hold",        32'(hold_ok), 32'd1);

        // Pointer increment
        for (int i = 0; i < 3; i++) send_bits(16'h0006, 6);
        chk("inc_addr", 32'(mem_addr), 32'd3);
        send_bits(16'h0002, 6);
        send_bits(16'h14B4, 16);
        send_bits(16'h0008, 6);
        chk("inc_we",    32'(mem_we),    32'd1);
        chk("inc_waddr", 32'(mem_addr),  32'd3);
        chk("inc_wdata", 32'(mem_wdata), 32'h0A5A);
        chk("inc_ferr",  32'(frame_err), 32'd0);
        wait_not_busy("inc_busy_end");

        // Wrap-around on the 3-bit instance
        send_bits(16'h0016, 6);
        for (int i = 0; i < 8; i++) send_bits(16'h0006, 6);
        send_bits(16'h0008, 6);
        chk("wrap_we",     32'(s_we),     32'd1);
        chk("wrap_addr",   32'(s_addr),   32'd0);
        chk("wide_addr",   32'(mem_addr), 32'd8);
        wait_not_busy("wrap_busy_end");

        // Framing error
        send_bits(16'h0002, 6);
        send_bits(16'h2468, 16);
        chk("frame_ok_wdata", 32'(mem_wdata), 32'h1234);
        chk("frame_ok_ferr",  32'(frame_err), 32'd0);
        send_bits(16'h0002, 6);
        send_bits(16'h8EEE, 16);
        chk("frame_bad_ferr",  32'(frame_err), 32'd1);
        chk("frame_bad_wdata", 32'(mem_wdata), 32'h1234);
        send_bits(16'h0008, 6);
        chk("frame_prog_we",    32'(mem_we),    32'd1);
        chk("frame_prog_wdata", 32'(mem_wdata), 32'h1234);
        wait_not_busy("frame_busy_end");
        prog_en = 1'b0;
        @(negedge clk);
        chk("ferr_clear", 32'(frame_err), 32'd0);
        chk("hold_off",   32'(cpu_hold),  32'd0);
        prog_en = 1'b1;
        @(negedge clk);
        send_bits(16'h003F, 6);
        chk("unknown_ferr", 32'(frame_err), 32'd1);
        chk("unknown_addr", 32'(mem_addr),  32'd8);

        // Abort after 3 command bits
        prog_en = 1'b0;
        @(negedge clk);
        prog_en = 1'b1;
        @(negedge clk);
        send_bits(16'h0016, 3);
        prog_en = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy),   32'd0);
        chk("abort_we",   32'(mem_we), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd8);
        prog_en = 1'b1;
        @(negedge clk);
        send_bits(16'h0016, 6);
        chk("reen_addr", 32'(mem_addr), 32'd0);
        chk("reen_ferr", 32'(frame_err), 32'd0);

        // Bit during WRITE is dropped and flagged
        send_bits(16'h0008, 6);
        chk("wbit_we", 32'(mem_we), 32'd1);
        bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0;
        chk("wbit_ferr", 32'(frame_err), 32'd1);
        chk("wbit_busy", 32'(busy),      32'd1);
        wait_not_busy("wbit_busy_end");
        send_bits(16'h0006, 6);
        chk("wbit_dropped_addr", 32'(mem_addr), 32'd1);

        // Drop prog_en during WRITE
        send_bits(16'h0008, 6);
        chk("drop_busy", 32'(busy), 32'd1);
        prog_en = 1'b0;
        hold_ok = 1'b1;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            if (cpu_hold !== 1'b1) hold_ok = 1'b0;
            nb++;
            @(negedge clk);
        end
        chk("drop_hold_during", 32'(hold_ok), 32'd1);
        chk("drop_busy_len",    32'(nb),      32'd4);
        chk("drop_hold_tail",   32'(cpu_hold), 32'd1);
        @(negedge clk);
        chk("drop_hold_off", 32'(cpu_hold),  32'd0);
        chk("drop_ferr",     32'(frame_err), 32'd0);
        chk("drop_idle_we",  32'(mem_we),    32'd0);

        // Reset during WRITE
        prog_en = 1'b1;
        @(negedge clk);
        send_bits(16'h0008, 6);
        chk("rw_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_we",    32'(mem_we),    32'd0);
        chk("rw_busy0", 32'(busy),      32'd0);
        chk("rw_addr",  32'(mem_addr),  32'd0);
        chk("rw_wdata", 32'(mem_wdata), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Serial in-system programming engine that writes 14-bit instruction words into the instruction memory the fetch stage reads from. A host shifts commands and data frames in one bit at a time. The loader holds the CPU in reset while programming is enabled, assembles words, and issues single-cycle write strobes to the memory's write port at an internal address pointer. It sits beside the instruction memory, on the write side of the same 13-bit-address / 14-bit-data interface the program counter and fetch logic read.

## Interface
Parameters:
- ADDR_W, 13, width of the instruction-memory address and pointer
- DATA_W, 14, instruction word width
- WR_WAIT, 4, length of the WRITE state in clk cycles (minimum 1)

Ports:
- clk  in  1  system clock; every register is updated on its rising edge
- reset  in  1  synchronous, active-high reset
- prog_en  in  1  programming-mode enable from the host
- bit_valid  in  1  one-cycle strobe qualifying bit_in
- bit_in  in  1  serial data bit, LSB first
- mem_addr  out  ADDR_W  address pointer, drives the memory write address
- mem_wdata  out  DATA_W  data latch, drives the memory write data
- mem_we  out  1  write strobe, exactly one cycle per write
- cpu_hold  out  1  forces the CPU reset while high
- busy  out  1  high in WRITE; the host must not send bits
- frame_err  out  1  sticky error flag, cleared by reset or by prog_en low

## Operation
- States:
  - IDLE
  - CMD: collects 6 bits
  - DATA: collects 16 bits
  - WRITE: lasts WR_WAIT cycles
- IDLE -> CMD:
  - Taken on the first cycle with prog_en=1.
  - The bit counter clears on entry to CMD or DATA.
- CMD decode, after the 6th valid bit, LSB first:
  - 6'h02 LOAD_DATA -> DATA.
  - 6'h06 INC_ADDR -> mem_addr+1, wrapping from all-ones to 0; back to CMD.
  - 6'h08 BEGIN_PROG -> WRITE.
  - 6'h16 RESET_ADDR -> mem_addr=0; back to CMD.
  - Any other code -> set frame_err, no action, back to CMD.
- DATA frame, 16 bits LSB first:
  - Bit 0 is the start bit and must be 0.
  - Bits 1..14 are the data word, bit 1 = word bit 0.
  - Bit 15 is the stop bit and must be 0.
  - Valid frame: mem_wdata is loaded with the assembled word.
  - Bad start or stop bit: mem_wdata is unchanged and frame_err is set.
  - Either way the next state is CMD.
- WRITE:
  - mem_we=1 on the first cycle only, with mem_addr/mem_wdata stable.
  - The remaining WR_WAIT-1 cycles are a wait.
  - busy=1 for all WR_WAIT cycles.
  - Exit to CMD.
  - mem_addr is not auto-incremented.
- bit_valid in WRITE: the bit is dropped and frame_err is set.
- bit_valid in IDLE: ignored.
- cpu_hold = prog_en | busy, registered. The CPU stays in reset until any write in flight has finished.
- prog_en low:
  - In IDLE/CMD/DATA: next state IDLE, partial bits discarded, mem_wdata and mem_addr retained, frame_err cleared.
  - In WRITE: the WRITE state runs to completion, then IDLE.
- mem_addr and mem_wdata persist across prog_en sessions; only reset or RESET_ADDR clears the pointer.

## Timing
- Reset values:
  - State = IDLE, bit counter = 0.
  - mem_addr = 0, mem_wdata = 0.
  - mem_we = 0, cpu_hold = 0, busy = 0, frame_err = 0.
- reset has priority over everything, including a WRITE in progress. mem_we is low in the cycle after reset is sampled.
- A bit is sampled on the clk edge where bit_valid=1. Back-to-back valid cycles are allowed in CMD and DATA.
- INC_ADDR / RESET_ADDR: mem_addr reflects the new value on the cycle after the edge sampling the 6th command bit.
- BEGIN_PROG: mem_we and busy rise on the cycle after the 6th command bit. busy falls WR_WAIT cycles later. A new bit is accepted on the first cycle with busy=0.
- LOAD_DATA: mem_wdata updates on the cycle after the 16th frame bit.
- cpu_hold follows prog_en | busy with 1 cycle of latency.
- frame_err rises on the cycle after the offending bit and stays high until cleared.

## Test plan
- Reset behaviour: hold reset 2 cycles with bits toggling -> all outputs 0, mem_addr=0.
- Basic write: prog_en=1, RESET_ADDR, LOAD_DATA with frame {0, 14'h3FFF, 0}, BEGIN_PROG -> mem_we high one cycle with addr=0, data=14'h3FFF; busy high exactly 4 cycles; cpu_hold=1 throughout.
- Pointer increment: INC_ADDR ×3, LOAD_DATA 14'h0A5A, BEGIN_PROG -> single write at addr 3, data 14'h0A5A; frame_err=0.
- Wrap-around (ADDR_W=3): RESET_ADDR, INC_ADDR ×8, BEGIN_PROG -> write at addr 0.
- Framing error: LOAD_DATA 14'h1234 OK, then LOAD_DATA with stop bit=1 -> frame_err=1 and mem_wdata stays 14'h1234. A following BEGIN_PROG writes 14'h1234. An unknown command 6'h3F also sets frame_err.
- Abort and busy: drop prog_en after 3 command bits -> IDLE, no write. Re-enable and send RESET_ADDR -> mem_addr=0. Pulse bit_valid during WRITE -> bit dropped, frame_err=1. Drop prog_en during WRITE -> cpu_hold stays 1 until busy falls.
